// File: rtl/pattern_det_pkg.sv
// Shared constants for the configurable serial pattern detector.
// Reset-time pattern/mode defaults and the history fill-counter width.
package pattern_det_pkg;

  localparam int PAT_W_DEF = 4;
  localparam logic [PAT_W_DEF-1:0] PAT_RST = 4'b1011;
  localparam logic OVL_RST = 1'b1;
  localparam int FILL_W = $clog2(PAT_W_DEF);

  // Fill counter width for any pattern length; never below one bit.
  function automatic int fill_width(input int pat_w);
    return (pat_w < 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/pattern_match_counter.sv
// Saturating match counter with synchronous clear and sticky saturation flag.
// Count and flag update on the same edge as the match pulse; clear beats increment.
module pattern_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MAX_M1 = {{(CNT_W-1){1'b1}}, 1'b0};

  logic [CNT_W-1:0] r_count;
  logic             r_sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (inc && (r_count != MAX)) begin
      r_count <= r_count + 1'b1;
      if (r_count == MAX_M1) r_sat <= 1'b1;
    end
  end

  assign count = r_count;
  assign sat   = r_sat;

endmodule

// File: rtl/pattern_detector_cfg.sv
// Runtime-configurable serial pattern detector (MSB-first), overlap or non-overlap mode.
// Registered one-cycle match pulse after the completing bit; matches counted with saturation.
module pattern_detector_cfg #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = pattern_det_pkg::PAT_RST,
  parameter logic             OVL_RST = pattern_det_pkg::OVL_RST,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             cnt_sat
);

  import pattern_det_pkg::*;

  localparam int W_FILL = fill_width(PAT_W);
  localparam logic [W_FILL-1:0] FILL_FULL = W_FILL'(PAT_W - 1);

  logic [PAT_W-2:0]  r_hist;
  logic [W_FILL-1:0] r_fill;
  logic [PAT_W-1:0]  r_pattern;
  logic              r_ovl;
  logic              r_match;

  logic [PAT_W-1:0]  w_shift;
  logic              w_hit;

  assign w_shift = {r_hist, in_bit};
  // A bit presented alongside cfg_load is dropped, so it can never complete a match.
  assign w_hit   = in_valid && !cfg_load && (r_fill == FILL_FULL) && (w_shift == r_pattern);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= PAT_RST;
      r_ovl     <= OVL_RST;
      r_match   <= 1'b0;
    end else if (cfg_load) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= cfg_pattern;
      r_ovl     <= cfg_overlap;
      r_match   <= 1'b0;
    end else if (in_valid) begin
      r_hist  <= w_shift[PAT_W-2:0];
      r_match <= w_hit;
      if (w_hit && !r_ovl)      r_fill <= '0;
      else if (r_fill != FILL_FULL) r_fill <= r_fill + 1'b1;
    end else begin
      r_match <= 1'b0;
    end
  end

  pattern_match_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_hit),
    .clr   (cnt_clr),
    .count (match_count),
    .sat   (cnt_sat)
  );

  assign match = r_match;

endmodule

// File: tb/tb_pattern_detector_cfg.sv
// Bench for pattern_detector_cfg: table of directed vectors plus hand-written corner sequences.
// A second instance with a 3-bit counter shares the stimulus for the saturation checks.
module tb_pattern_detector_cfg;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
  logic [3:0] cfg_pattern;
  logic       match8, sat8, match3, sat3;
  logic [7:0] cnt8;
  logic [2:0] cnt3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pattern_detector_cfg dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .match(match8), .match_count(cnt8), .cnt_sat(sat8)
  );

  pattern_detector_cfg #(.CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .match(match3), .match_count(cnt3), .cnt_sat(sat3)
  );

  typedef struct {
    logic       vld;
    logic       b;
    logic       ld;
    logic [3:0] pat;
    logic       ovl;
    logic       clr;
    logic       em;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic vld, input logic b, input logic ld,
                              input logic [3:0] pat, input logic ovl, input logic clr,
                              input logic em, input logic [7:0] ec);
    vec_t v;
    v.vld = vld; v.b = b; v.ld = ld; v.pat = pat; v.ovl = ovl; v.clr = clr;
    v.em = em; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic vld, input logic b, input logic ld,
                      input logic [3:0] pat, input logic ovl, input logic clr);
    @(negedge clk);
    in_valid = vld; in_bit = b; cfg_load = ld; cfg_pattern = pat;
    cfg_overlap = ovl; cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    step(1'b1, b, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] seq3;
    logic [6:0] seq_ovl;
    int k;

    // Overlapping 1011 stream: 1,0,1,1,0,1,1
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 1, 8'd1));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 1, 8'd2));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 8'd2));
    // Reload 1011 non-overlapping, clearing the count; stream 1,0,1,1,0,1,1,0,1,1
    tbl.push_back(mk(0, 0, 1, 4'b1011, 0, 1, 0, 8'd0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 1, 8'd1));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 1, 8'd2));

    reset = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0; cfg_pattern = 4'b0000;
    cfg_overlap = 1'b0; cnt_clr = 1'b0;
    #3;
    chk("rst_match", {31'd0, match8}, 32'd0);
    chk("rst_count", {24'd0, cnt8}, 32'd0);
    chk("rst_sat", {31'd0, sat8}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].b, tbl[i].ld, tbl[i].pat, tbl[i].ovl, tbl[i].clr);
      chk($sformatf("tbl%0d_match", i), {31'd0, match8}, {31'd0, tbl[i].em});
      chk($sformatf("tbl%0d_count", i), {24'd0, cnt8}, {24'd0, tbl[i].ec});
    end

    // Bits separated by 3-cycle in_valid gaps
    step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
    seq3 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      bit_in(seq3[3-i]);
      chk($sformatf("gap_bit%0d_match", i), {31'd0, match8}, {31'd0, (i == 3)});
      for (int g = 0; g < 3; g++) begin
        idle();
        chk($sformatf("gap_bit%0d_idle%0d", i, g), {31'd0, match8}, 32'd0);
      end
    end
    chk("gap_count", {24'd0, cnt8}, 32'd1);

    // Saturation: 12 ones against 1111 overlapping gives 9 matches
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      bit_in(1'b1);
      k = (i >= 3) ? i - 2 : 0;
      chk($sformatf("sat_b%0d_match", i), {31'd0, match3}, {31'd0, (i >= 3)});
      chk($sformatf("sat_b%0d_cnt3", i), {29'd0, cnt3}, (k > 7) ? 32'd7 : k);
      chk($sformatf("sat_b%0d_sat3", i), {31'd0, sat3}, {31'd0, (k >= 7)});
      chk($sformatf("sat_b%0d_cnt8", i), {24'd0, cnt8}, k);
    end
    chk("sat_sat8", {31'd0, sat8}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    chk("clr_cnt3", {29'd0, cnt3}, 32'd0);
    chk("clr_sat3", {31'd0, sat3}, 32'd0);
    chk("clr_cnt8", {24'd0, cnt8}, 32'd0);

    // cfg_load coincident with the completing bit drops it and empties the history
    step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    step(1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b0);
    chk("ldcoll_match", {31'd0, match8}, 32'd0);
    bit_in(1'b1);
    chk("ldcoll_nohist", {31'd0, match8}, 32'd0);
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    chk("ldcoll_fresh_match", {31'd0, match8}, 32'd1);
    chk("ldcoll_fresh_count", {24'd0, cnt8}, 32'd1);

    // cnt_clr coincident with an overlapping hit: pulse survives, count clears
    bit_in(1'b0); bit_in(1'b1);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    chk("clrhit_match", {31'd0, match8}, 32'd1);
    chk("clrhit_count", {24'd0, cnt8}, 32'd0);
    chk("clrhit_cnt3", {29'd0, cnt3}, 32'd0);

    // Asynchronous reset mid-pattern; history 101 must not complete afterwards
    seq_ovl = 7'b1011101;
    for (int i = 0; i < 7; i++) bit_in(seq_ovl[6-i]);
    chk("prerst_count", {24'd0, cnt8}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("asyncrst_match", {31'd0, match8}, 32'd0);
    chk("asyncrst_count", {24'd0, cnt8}, 32'd0);
    chk("asyncrst_sat", {31'd0, sat8}, 32'd0);
    #3;
    reset = 1'b1;
    bit_in(1'b1);
    chk("postrst_match", {31'd0, match8}, 32'd0);
    idle();
    chk("postrst_idle_match", {31'd0, match8}, 32'd0);
    chk("postrst_count", {24'd0, cnt8}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
